// File: rtl/button_event_decoder_if.sv
// Bundles the button level and its decoded event pulses into one port.
// Latency: none, wires only.
// Backpressure: none; every pulse lasts one cycle and is never held for a consumer.
interface button_event_decoder_if;
    logic button_in;
    logic press_pulse;
    logic release_pulse;
    logic short_click;
    logic double_click;
    logic long_press;
    logic held;

    // Stimulus side: drives the button level and observes the events
    modport master (
        output button_in,
        input  press_pulse, release_pulse, short_click, double_click, long_press, held
    );

    // Decoder side: samples the button level and produces the events
    modport slave (
        input  button_in,
        output press_pulse, release_pulse, short_click, double_click, long_press, held
    );
endinterface

// File: rtl/button_event_decoder.sv
// Decodes a debounced button level into press/release edges and short/double/long clicks.
// Latency: one cycle; an event sampled at edge N is visible in the cycle after edge N.
// Backpressure: none; every output is a single-cycle registered pulse (held is a level).
module button_event_decoder #(
    parameter int LONG_CYCLES = 100,
    parameter int GAP_CYCLES  = 30,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    button_event_decoder_if.slave bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PRESS1    = 3'd1;
    localparam logic [2:0] S_WAIT_GAP  = 3'd2;
    localparam logic [2:0] S_PRESS2    = 3'd3;
    localparam logic [2:0] S_LONG_HELD = 3'd4;

    localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             in_q;
    logic             rise, fall;
    logic             press_q, release_q, short_q, double_q, long_q;
    logic             short_d, double_d, long_d;

    assign rise    = bus.button_in & ~in_q;
    assign fall    = ~bus.button_in & in_q;
    assign cnt_inc = cnt_q + ONE_C;

    // Next-state logic; the counter only advances while it is below its target, so it never wraps
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESS1;
                    cnt_d   = ONE_C;
                end
            end
            S_PRESS1: begin
                // A release always wins, even on the sample that would have completed a long press
                if (!bus.button_in) begin
                    state_d = S_WAIT_GAP;
                    cnt_d   = ONE_C;
                end else if (cnt_inc == LONG_C) begin
                    long_d  = 1'b1;
                    state_d = S_LONG_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT_GAP: begin
                if (bus.button_in) begin
                    double_d = 1'b1;
                    state_d  = S_PRESS2;
                    cnt_d    = '0;
                end else if (cnt_inc == GAP_C) begin
                    short_d = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_PRESS2: begin
                if (!bus.button_in) begin
                    state_d = S_IDLE;
                end
            end
            S_LONG_HELD: begin
                if (!bus.button_in) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, sampled level and registered event pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            in_q      <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in_q      <= bus.button_in;
            press_q   <= rise;
            release_q <= fall;
            short_q   <= short_d;
            double_q  <= double_d;
            long_q    <= long_d;
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.short_click   = short_q;
    assign bus.double_click  = double_q;
    assign bus.long_press    = long_q;
    assign bus.held          = in_q;

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 The block SHALL have parameter LONG_CYCLES, default 100, consecutive high samples that qualify a long press (legal range 2 to 2^CNT_W-1).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 30, consecutive low samples after a short press that close the double-click window (legal range 2 to 2^CNT_W-1).
REQ-003 The block SHALL have parameter CNT_W, default 16, counter width.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 button_in  input  1  debounced button level (debouncer output), synchronous to clk, 1 = pressed.
REQ-007 press_pulse  output  1  one-cycle pulse per rising edge of button_in.
REQ-008 release_pulse  output  1  one-cycle pulse per falling edge of button_in.
REQ-009 short_click  output  1  one-cycle pulse for a single short press with no follow-up inside the gap window.
REQ-010 double_click  output  1  one-cycle pulse on the second press inside the gap window.
REQ-011 long_press  output  1  one-cycle pulse when a press reaches LONG_CYCLES high samples.
REQ-012 held  output  1  registered copy of button_in (in_q).

Function
REQ-013 All outputs SHALL be registered; an event sampled at clock edge N SHALL be visible in the cycle after edge N.
REQ-014 Edge detection SHALL compare sampled button_in against in_q: rise = button_in & ~in_q; fall = ~button_in & in_q.
REQ-015 press_pulse and release_pulse SHALL fire on every rise or fall, in every FSM state.
REQ-016 FSM states SHALL be IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD; a one-hot or binary encoding is permitted.
REQ-017 IDLE: on rise -> PRESS1, cnt <= 1; otherwise stay in IDLE.
REQ-018 PRESS1, button_in=1: if cnt+1 == LONG_CYCLES -> long_press pulse, go to LONG_HELD; else cnt <= cnt+1.
REQ-019 PRESS1, button_in=0 -> WAIT_GAP, cnt <= 1; no click pulse yet.
REQ-020 WAIT_GAP, button_in=1 -> double_click pulse, go to PRESS2 (same edge as press_pulse).
REQ-021 WAIT_GAP, button_in=0: if cnt+1 == GAP_CYCLES -> short_click pulse, go to IDLE; else cnt <= cnt+1.
REQ-022 PRESS2: no long-press detection; button_in=0 -> IDLE.
REQ-023 LONG_HELD: button_in=0 -> IDLE; no short_click after a long press.
REQ-024 At most one of short_click, double_click, long_press SHALL be high in any cycle.
REQ-025 cnt SHALL never exceed max(LONG_CYCLES, GAP_CYCLES) and SHALL never wrap.
REQ-026 A release at the edge where cnt+1 would reach LONG_CYCLES SHALL be treated as a release (REQ-019), not as a long press.
REQ-027 A press lasting exactly one sample (rise, then low at the next edge) SHALL be a valid short press.

Reset
REQ-028 While rst=1, regardless of clk, all outputs, in_q and cnt SHALL be 0 and the state SHALL be IDLE.
REQ-029 After rst deasserts with button_in=1, the first clock edge SHALL produce press_pulse and enter PRESS1, because in_q resets to 0.
REQ-030 rst asserted mid-sequence SHALL discard the pending event; no short_click, long_press or double_click SHALL fire for it.

Verification (LONG_CYCLES=8, GAP_CYCLES=4)
REQ-031 Reset: rst=1, button_in=0 for 3 cycles, then rst=0 for 10 cycles -> every output 0 throughout.
REQ-032 Short click: button_in high 3 samples, then low -> press_pulse x1, release_pulse x1, short_click x1 on the 4th low sample, no long_press or double_click.
REQ-033 Long press: button_in high 12 samples, then low -> long_press x1 on the 8th high sample, release_pulse x1, no short_click.
REQ-034 Double click: high 2, low 2, high 2, low 6 -> press_pulse x2, double_click x1 on the second rise sample, no short_click.
REQ-035 Gap expiry: high 2, low 4, high 2, low 6 -> short_click x2 (4th low sample of each gap), no double_click.
REQ-036 Reset mid-press: rst pulsed while in PRESS1 with button_in held -> outputs 0 during reset, press_pulse on the first edge after release, long_press 7 edges later if the button stays held.
